// File: rtl/decouple_fifo.sv
// ---------------------------------------------------------------------------
// decouple_fifo
//
// DEPTH-entry elastic buffer between a valid/ready consumer port (din_*) and
// a valid/ready producer port (dout_*). din_ready comes from a register, so
// there is no combinational path from dout_ready back to din_ready.
//
// With OPT_OUTREG=1 an extra output register sits after the storage array.
// Capacity is then DEPTH+1, and a word pushed into an empty buffer bypasses
// the array straight into that register. With OPT_OUTREG=0, dout_data is read
// directly from the array head and capacity is DEPTH. Either way, a push into
// an empty buffer shows up on dout one cycle later.
//
// Parameters:
//   W            payload width
//   DEPTH        storage array entries (power of two, >= 2)
//   OPT_OUTREG   1 = registered output stage, 0 = array head drives dout_data
//   OPT_LOWPOWER 1 = dout_data is 0 whenever dout_valid is 0
//   ALMOST_FULL  almost_full threshold, 1..CAP
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   flush        synchronous clear of all contents (blocks pushes this cycle)
//   din_data     input payload
//   din_valid    input valid
//   din_ready    input ready (registered, gated by flush)
//   dout_data    output payload
//   dout_valid   output valid
//   dout_ready   output ready
//   count        occupancy, output register included
//   almost_full  count >= ALMOST_FULL, registered alongside count
// ---------------------------------------------------------------------------
module decouple_fifo #(
  parameter int W            = 8,
  parameter int DEPTH        = 4,
  parameter int OPT_OUTREG   = 1,
  parameter int OPT_LOWPOWER = 0,
  parameter int ALMOST_FULL  = DEPTH - 1,
  localparam int CAP         = DEPTH + ((OPT_OUTREG != 0) ? 1 : 0),
  localparam int CW          = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [W-1:0]  din_data,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [W-1:0]  dout_data,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [CW-1:0] count,
  output logic          almost_full
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_r;
  logic [CW-1:0] next_count;
  logic          ready_r;
  logic          af_r;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;

  // Handshakes and occupancy bookkeeping shared by both output styles.
  assign din_ready   = ready_r & ~flush;
  assign push        = din_valid & din_ready;
  assign pop         = dout_valid & dout_ready;
  assign count       = count_r;
  assign almost_full = af_r;

  // Cannot overflow: push only happens while count_r < CAP.
  // It cannot underflow either: pop needs dout_valid, and dout_valid
  // implies count_r > 0.
  assign next_count = count_r + CW'(push) - CW'(pop);

  // NOTE: all sequential state uses non-blocking assignments. Every register
  // then samples the pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_r <= '0;
      ready_r <= 1'b1;
      af_r    <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      count_r <= next_count;
      ready_r <= (next_count < CW'(CAP));
      af_r    <= (next_count >= CW'(ALMOST_FULL));
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset. The pointers and count decide what
  // is valid, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din_data;
  end

  if (OPT_OUTREG != 0) begin : g_outreg
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_load;
    logic         arr_nonempty;
    logic         bypass;

    // The output register is occupied whenever anything is buffered.
    // So count_r > 1 means the array itself holds at least one word.
    assign arr_nonempty = (count_r > CW'(1));
    assign out_load     = ~out_valid | dout_ready;
    assign bypass       = out_load & ~arr_nonempty & push;
    assign rd_en        = out_load & arr_nonempty;
    // The array is written only when the output register stays occupied.
    assign wr_en        = push & ~bypass;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        out_valid <= 1'b0;
        if (OPT_LOWPOWER != 0) out_data <= '0;
      end else if (out_load) begin
        out_valid <= arr_nonempty | push;
        if (arr_nonempty)            out_data <= mem[rd_ptr];
        else if (push)               out_data <= din_data;
        else if (OPT_LOWPOWER != 0)  out_data <= '0;
      end
    end

    assign dout_valid = out_valid;
    assign dout_data  = out_data;
  end else begin : g_direct
    assign wr_en      = push;
    assign rd_en      = pop;
    assign dout_valid = (count_r != '0);
    assign dout_data  = ((OPT_LOWPOWER != 0) && !dout_valid) ? '0 : mem[rd_ptr];
  end

endmodule
